// File: rtl/seq_multiplier.sv
// Sequential radix-2 Booth multiplier for signed operands.
// One Booth step per clock; the result lands WIDTH-1 cycles after the accept edge.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      step_q, step_d;
  logic [WIDTH:0]     mcand_q, mcand_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic               q1_q, q1_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               load;
  logic [WIDTH:0]     src_m, src_acc, sum, acc_sh;
  logic [WIDTH-1:0]   src_mplr, mplr_sh;
  logic               src_q1;

  // Step 0 runs on the raw inputs so the accept edge already does work.
  always_comb begin
    load     = (state_q == IDLE) && start;
    src_m    = load ? {multiplicand[WIDTH-1], multiplicand} : mcand_q;
    src_acc  = load ? '0 : acc_q;
    src_mplr = load ? multiplier : mplr_q;
    src_q1   = load ? 1'b0 : q1_q;
    unique case ({src_mplr[0], src_q1})
      2'b01:   sum = src_acc + src_m;
      2'b10:   sum = src_acc - src_m;
      default: sum = src_acc;
    endcase
    acc_sh  = {sum[WIDTH], sum[WIDTH:1]};
    mplr_sh = {sum[0], src_mplr[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    q1_d    = q1_q;
    ready_d = ready_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = src_m;
          acc_d   = acc_sh;
          mplr_d  = mplr_sh;
          q1_d    = src_mplr[0];
          step_d  = CW'(1);
          ready_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d  = acc_sh;
        mplr_d = mplr_sh;
        q1_d   = src_mplr[0];
        if (step_q == CW'(WIDTH - 1)) begin
          prod_d  = {acc_sh[WIDTH-1:0], mplr_sh};
          ready_d = 1'b1;
          step_d  = '0;
          state_d = IDLE;
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      q1_q    <= 1'b0;
      ready_q <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      q1_q    <= q1_d;
      ready_q <= ready_d;
      prod_q  <= prod_d;
    end
  end

  assign ready   = ready_q;
  assign product = prod_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and sweep bench for the 16-bit Booth multiplier.
// Product and latency are checked for every operation.
module tb_seq_multiplier;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic [2*W-1:0] product;

  int errors;
  int checks;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (a),
    .multiplier   (b),
    .ready        (ready),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #23;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got=%b want=0", ready);
    end
    checks++;
    if (product !== '0) begin
      errors++;
      $display("FAIL reset_product got=%0d want=0", product);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors(input string tag,
                              input logic [W-1:0] av[3],
                              input logic [W-1:0] bv[3],
                              input logic [2*W-1:0] ev[3]);
    int n;
    for (int i = 0; i < 3; i++) begin
      launch(av[i], bv[i]);
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_%0d_busy_ready got=%b want=0", tag, i, ready);
      end
      wait_done(n);
      checks++;
      if (n !== 15) begin
        errors++;
        $display("FAIL %s_%0d_latency got=%0d want=15", tag, i, n);
      end
      checks++;
      if (product !== ev[i]) begin
        errors++;
        $display("FAIL %s_%0d_product got=%0d want=%0d", tag, i,
                 $signed(product), $signed(ev[i]));
      end
    end
  endtask

  task automatic test_zero;
    test_vectors("zero",
      '{16'sd0, 16'sd32767, -16'sd32768},
      '{16'sd0, 16'sd0, 16'sd0},
      '{32'sd0, 32'sd0, 32'sd0});
  endtask

  task automatic test_basic;
    test_vectors("basic",
      '{16'sd1, 16'sd32767, -16'sd1},
      '{16'sd1, 16'sd1, -16'sd1},
      '{32'sd1, 32'sd32767, 32'sd1});
    test_vectors("neg",
      '{16'sd32767, 16'sd3, -16'sd7},
      '{-16'sd1, -16'sd5, 16'sd9},
      '{-32'sd32767, -32'sd15, -32'sd63});
  endtask

  task automatic test_extremes;
    test_vectors("ext",
      '{16'sd32767, 16'sd32767, -16'sd32768},
      '{16'sd32767, -16'sd32768, -16'sd32768},
      '{32'sd1073676289, -32'sd1073709056, 32'sd1073741824});
  endtask

  task automatic test_busy_ignore;
    int n;
    launch(16'sd1234, -16'sd567);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (product !== 32'sd1073741824 || ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_hold got=%0d/%b want=1073741824/0",
               $signed(product), ready);
    end
    a     = 16'sd9;
    b     = 16'sd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 11) begin
      errors++;
      $display("FAIL busy_latency got=%0d want=11", n);
    end
    checks++;
    if (product !== -32'sd699678) begin
      errors++;
      $display("FAIL busy_product got=%0d want=-699678", $signed(product));
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1 || product !== -32'sd699678) begin
      errors++;
      $display("FAIL idle_hold got=%0d/%b want=-699678/1",
               $signed(product), ready);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    launch(16'sd100, 16'sd200);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (product !== '0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset got=%0d/%b want=0/0", $signed(product), ready);
    end
    #10;
    rst_n = 1'b1;
    launch(-16'sd300, 16'sd77);
    wait_done(n);
    checks++;
    if (n !== 15 || product !== -32'sd23100) begin
      errors++;
      $display("FAIL after_reset got=%0d lat=%0d want=-23100 lat=15",
               $signed(product), n);
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 300;
    logic [W-1:0] av[N];
    logic [W-1:0] bv[N];
    logic [2*W-1:0] ev;
    int n;
    for (int i = 0; i < N; i++) begin
      if (i < 200) begin
        av[i] = W'(i - 100);
        bv[i] = W'(i - 90);
      end else begin
        av[i] = W'($urandom);
        bv[i] = W'($urandom);
      end
    end
    @(negedge clk);
    a     = av[0];
    b     = bv[0];
    start = 1'b1;
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_%0d_accept ready=%b want=0", k, ready);
      end
      if (k + 1 < N) begin
        a = av[k+1];
        b = bv[k+1];
      end else begin
        start = 1'b0;
      end
      ev = 32'(longint'($signed(av[k])) * longint'($signed(bv[k])));
      wait_done(n);
      checks++;
      if (n !== 15 || product !== ev) begin
        errors++;
        $display("FAIL b2b_%0d got=%0d lat=%0d want=%0d lat=15",
                 k, $signed(product), n, $signed(ev));
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_zero;
    test_basic;
    test_extremes;
    test_busy_ignore;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
